// File: rtl/usb_serial_rx_buffer.sv
// Host-to-device byte buffer: 2^ASIZE FIFO with overflow drop/count and a valid/ready output stage.
// Optional registered occupancy output enabled by USB_SERIAL_RX_LEVEL_EN.
module usb_serial_rx_buffer #(
  parameter int unsigned ASIZE = 10
) (
  input  logic             clk,
  input  logic             usb_rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  input  logic             ovf_clr,
  output logic [ASIZE:0]   level
);

  localparam int unsigned   DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  logic [7:0]     mem [DEPTH];
  state_e         state_q;
  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [7:0]     out_data_q;
  logic           out_valid_q;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           empty, full, wr_en, drop, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q == {~rptr_q[ASIZE], rptr_q[ASIZE-1:0]});
  assign wr_en = in_valid && !full;
  assign drop  = in_valid && full;
  assign rd_en = (state_q == READ);

  always_comb begin
    wptr_d     = wr_en ? wptr_q + PTR_ONE : wptr_q;
    rptr_d     = rd_en ? rptr_q + PTR_ONE : rptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A drop in the same cycle as a clear wins: the count restarts at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr)
        drop_cnt_d = 16'd1;
      else if (drop_cnt_q != '1)
        drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr_q[ASIZE-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty)
            state_q <= READ;
        end
        READ: begin
          out_data_q  <= mem[rptr_q[ASIZE-1:0]];
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef USB_SERIAL_RX_LEVEL_EN
  logic [ASIZE:0] level_q;

  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn)
      level_q <= '0;
    else
      level_q <= wptr_q - rptr_q;
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_usb_serial_rx_buffer.sv
// Bench for usb_serial_rx_buffer: two instances (ASIZE=2 and ASIZE=10) against a timestamp-based queue model.
module tb_usb_serial_rx_buffer;

  logic        clk = 1'b0;
  logic        usb_rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        ovf_clr;

  logic [7:0]  s_data,  l_data;
  logic        s_valid, l_valid;
  logic        s_ovf,   l_ovf;
  logic [15:0] s_cnt,   l_cnt;
  logic [2:0]  s_level;
  logic [10:0] l_level;

  int tests = 0;
  int fails = 0;
  int t = 0;

  // model: per instance, queued bytes with their write edges, output stage and drop state
  logic [7:0] mq [2][$];
  int         mw [2][$];
  bit         mbusy [2];
  int         mfree [2];
  logic [7:0] mout [2];
  bit         movf [2];
  int         mcnt [2];
  int         mlvl [2];

  always #5 clk = ~clk;

  usb_serial_rx_buffer #(.ASIZE(2)) dut_s (
    .clk(clk), .usb_rstn(usb_rstn), .in_data(in_data), .in_valid(in_valid),
    .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
    .overflow(s_ovf), .drop_cnt(s_cnt), .ovf_clr(ovf_clr), .level(s_level));

  usb_serial_rx_buffer #(.ASIZE(10)) dut_l (
    .clk(clk), .usb_rstn(usb_rstn), .in_data(in_data), .in_valid(in_valid),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overflow(l_ovf), .drop_cnt(l_cnt), .ovf_clr(ovf_clr), .level(l_level));

  function automatic int depth(int d);
    return (d == 0) ? 4 : 1024;
  endfunction

  function automatic logic [25:0] got_vec(int d);
    return (d == 0) ? {s_valid, s_data, s_ovf, s_cnt} : {l_valid, l_data, l_ovf, l_cnt};
  endfunction

  function automatic logic [25:0] exp_vec(int d);
    return {mbusy[d], mout[d], movf[d], 16'(mcnt[d])};
  endfunction

  function automatic int got_lvl(int d);
    return (d == 0) ? int'(s_level) : int'(l_level);
  endfunction

  function automatic int exp_lvl(int d);
`ifdef USB_SERIAL_RX_LEVEL_EN
    return mlvl[d];
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mw[d].delete();
      mbusy[d] = 0; mfree[d] = 0; mout[d] = 8'h00;
      movf[d] = 0; mcnt[d] = 0; mlvl[d] = 0;
    end
  endtask

  // Byte leaves the FIFO two edges after both it is stored and the output stage is free.
  task automatic step();
    t++;
    if (usb_rstn) begin
      for (int d = 0; d < 2; d++) begin
        int sz;
        int due;
        bit acc, rd, drp;
        sz  = mq[d].size();
        acc = mbusy[d] && out_ready;
        rd  = 0;
        if (!mbusy[d] && sz > 0) begin
          due = ((mw[d][0] > mfree[d]) ? mw[d][0] : mfree[d]) + 2;
          rd  = (t == due);
        end
        drp = in_valid && (sz == depth(d));
        if (acc) begin mbusy[d] = 0; mfree[d] = t; end
        if (rd) begin mout[d] = mq[d].pop_front(); void'(mw[d].pop_front()); mbusy[d] = 1; end
        if (in_valid && !drp) begin mq[d].push_back(in_data); mw[d].push_back(t); end
        if (drp) begin
          movf[d] = 1;
          mcnt[d] = ovf_clr ? 1 : ((mcnt[d] < 65535) ? mcnt[d] + 1 : 65535);
        end else if (ovf_clr) begin
          movf[d] = 0; mcnt[d] = 0;
        end
        mlvl[d] = sz;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    usb_rstn = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    step(); step();
    usb_rstn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (got_vec(d) !== 26'h0) begin
        fails++; $display("FAIL reset_outputs dut%0d got=%h exp=%h", d, got_vec(d), 26'h0);
      end
      tests++;
      if (got_lvl(d) !== 0) begin
        fails++; $display("FAIL reset_level dut%0d got=%0d exp=0", d, got_lvl(d));
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] rx[$];
    logic [7:0] want [3];
    int first_k;
    want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43;
    first_k = -1;
    out_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      in_valid = (k <= 3);
      in_data  = (k <= 3) ? want[k-1] : 8'h00;
      if (s_valid && out_ready) rx.push_back(s_data);
      step();
      if (s_valid && first_k < 0) first_k = k;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL basic_cycle dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), exp_vec(d));
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if (first_k != 3) begin
      fails++; $display("FAIL basic_latency got_edge=%0d exp_edge=3", first_k);
    end
    tests++;
    if (rx.size() != 3) begin
      fails++; $display("FAIL basic_count got=%0d exp=3", rx.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rx[i] !== want[i]) begin
          fails++; $display("FAIL basic_data idx=%0d got=%h exp=%h", i, rx[i], want[i]);
        end
      end
    end
    tests++;
    if (s_ovf !== 1'b0) begin
      fails++; $display("FAIL basic_overflow got=%b exp=0", s_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] rx[$];
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(k);
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL ovf_fill dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), exp_vec(d));
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if ({s_ovf, s_cnt} !== {1'b1, 16'd1}) begin
      fails++; $display("FAIL ovf_flag got=%b/%0d exp=1/1", s_ovf, s_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (s_valid && out_ready) rx.push_back(s_data);
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL ovf_drain dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), exp_vec(d));
        end
      end
    end
    tests++;
    if (rx.size() != 5) begin
      fails++; $display("FAIL ovf_count got=%0d exp=5", rx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (rx[i] !== 8'h10 + 8'(i)) begin
          fails++; $display("FAIL ovf_data idx=%0d got=%h exp=%h", i, rx[i], 8'h10 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    tests++;
    if ({s_ovf, s_cnt} !== {1'b0, 16'd0}) begin
      fails++; $display("FAIL clr_lone1 got=%b/%0d exp=0/0", s_ovf, s_cnt);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      ovf_clr  = (k == 8);
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL clr_fill dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), exp_vec(d));
        end
      end
      if (k == 7) begin
        tests++;
        if ({s_ovf, s_cnt} !== {1'b1, 16'd3}) begin
          fails++; $display("FAIL clr_three got=%b/%0d exp=1/3", s_ovf, s_cnt);
        end
      end
    end
    in_valid = 1'b0; ovf_clr = 1'b0;
    tests++;
    if ({s_ovf, s_cnt} !== {1'b1, 16'd1}) begin
      fails++; $display("FAIL clr_drop_wins got=%b/%0d exp=1/1", s_ovf, s_cnt);
    end
    step();
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    tests++;
    if ({s_ovf, s_cnt} !== {1'b0, 16'd0}) begin
      fails++; $display("FAIL clr_lone2 got=%b/%0d exp=0/0", s_ovf, s_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL clr_drain dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    logic [7:0] rx[$];
    out_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 40; k++) begin
        in_valid = (k == 0);
        in_data  = (k == 0) ? 8'($urandom) : 8'h00;
        if (k == 0) sent.push_back(in_data);
        if (s_valid && out_ready) rx.push_back(s_data);
        step();
      end
    end
    in_valid = 1'b0;
    tests++;
    if (rx.size() != 20) begin
      fails++; $display("FAIL wrap_count got=%0d exp=20", rx.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        tests++;
        if (rx[i] !== sent[i]) begin
          fails++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, rx[i], sent[i]);
        end
      end
    end
    tests++;
    if ({s_ovf, s_cnt} !== {1'b0, 16'd0}) begin
      fails++; $display("FAIL wrap_nodrop got=%b/%0d exp=0/0", s_ovf, s_cnt);
    end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(k); step();
    end
    in_valid = 1'b0;
    step(); step();
    tests++;
    if (s_valid !== 1'b1) begin
      fails++; $display("FAIL rsthold_pre got=%b exp=1", s_valid);
    end
    usb_rstn = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (got_vec(d) !== 26'h0) begin
        fails++; $display("FAIL rsthold_async dut%0d got=%h exp=%h", d, got_vec(d), 26'h0);
      end
    end
    step(); step();
    usb_rstn = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== 26'h0) begin
          fails++; $display("FAIL rsthold_stale dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), 26'h0);
        end
        tests++;
        if (got_lvl(d) !== 0) begin
          fails++; $display("FAIL rsthold_level dut%0d got=%0d exp=0", d, got_lvl(d));
        end
      end
    end
  endtask

  task automatic test_level();
    int want;
`ifdef USB_SERIAL_RX_LEVEL_EN
    want = 4;
`else
    want = 0;
`endif
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 5); in_data = 8'($urandom);
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_lvl(d) !== exp_lvl(d)) begin
          fails++; $display("FAIL level_cycle dut%0d t=%0d got=%0d exp=%0d", d, t, got_lvl(d), exp_lvl(d));
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if (got_lvl(1) !== want) begin
      fails++; $display("FAIL level_settle got=%0d exp=%0d", got_lvl(1), want);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) step();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (got_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL level_drain dut%0d got=%h exp=%h", d, got_vec(d), exp_vec(d));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 63) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (got_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL random_cycle dut%0d t=%0d got=%h exp=%h", d, t, got_vec(d), exp_vec(d));
        end
        tests++;
        if (got_lvl(d) !== exp_lvl(d)) begin
          fails++; $display("FAIL random_level dut%0d t=%0d got=%0d exp=%0d", d, t, got_lvl(d), exp_lvl(d));
        end
      end
    end
    in_valid = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ovf_clr();
    test_wrap();
    test_reset_hold();
    test_level();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_serial_rx_buffer.md
Name: usb_serial_rx_buffer

Overview:
- Receive-side (host-to-device) byte buffer for the USB-CDC serial function. It is the counterpart of the device-to-host send buffer.
- Captures the unthrottled byte pulses from the core's OUT endpoint 0x01 (ep01_data/ep01_valid) into a 2^ASIZE-byte FIFO.
- Presents the bytes to user logic through a valid/ready handshake.
- The core cannot be back-pressured, so the block also detects overflow, drops the excess bytes and counts them.

Parameters:
- ASIZE, 10, FIFO depth = 2^ASIZE bytes (legal range 2..14); memory is a plain array with synchronous read (BRAM-inferable).

Ports:
- clk  input  1  system clock, 60 MHz
- usb_rstn  input  1  asynchronous active-low reset; clock clk
- in_data  input  8  byte from core OUT endpoint 0x01
- in_valid  input  1  single-cycle pulse; in_data is valid in that cycle; no ready path back to the core
- out_data  output  8  received byte to user
- out_valid  output  1  out_data holds a byte
- out_ready  input  1  user accepts the byte when out_valid=1 and out_ready=1 at the same edge
- overflow  output  1  sticky flag: at least one byte was dropped
- drop_cnt  output  16  saturating count of dropped bytes
- ovf_clr  input  1  one-cycle pulse; clears overflow and drop_cnt
- level  output  ASIZE+1  FIFO occupancy (see Optional Feature)

Behaviour:
- Reset (usb_rstn=0, asynchronous): wptr=rptr=0; state=IDLE; out_valid=0; out_data=0; overflow=0; drop_cnt=0; level=0. All FIFO contents are discarded. Reset mid-transfer loses the byte held in the output stage.
- Pointers: wptr and rptr are ASIZE+1 bits, wrap modulo 2^(ASIZE+1).
  - empty: wptr==rptr
  - full: wptr=={~rptr[ASIZE], rptr[ASIZE-1:0]}
  - Occupancy counts FIFO entries only; it excludes the byte held in the output stage.
- Write: if in_valid=1 and the FIFO is not full at edge N, mem[wptr[ASIZE-1:0]] is written with in_data and wptr increments.
- Drop: if in_valid=1 and the FIFO is full, the byte is discarded, wptr is unchanged, overflow is set to 1 and drop_cnt increments, saturating at 0xFFFF.
- ovf_clr=1 with no drop in the same cycle: overflow=0, drop_cnt=0.
- ovf_clr=1 and a drop in the same cycle: overflow=1, drop_cnt=1 (the drop wins).
- Output FSM, three states:
  - IDLE: out_valid=0. Go to READ if not empty.
  - READ: issue a synchronous read at rptr; rptr increments at this edge; out_data is registered from memory. Go to HOLD.
  - HOLD: out_valid=1; out_data is stable. When out_valid and out_ready are both 1 at an edge, go to IDLE; otherwise stay in HOLD.
- Latency: a byte written at edge N (FIFO and output stage both empty) gives out_valid=1 after edge N+2.
- Throughput: one byte per 3 cycles. This exceeds the USB FS byte rate (about 1 per 40 clk) by a wide margin.
- Write at the full boundary: a write in the same cycle as the READ-state rptr increment is judged against the pre-edge pointers. Full means drop, even though a slot frees at that edge.
- Write to empty in the same cycle the FSM is in IDLE: the FSM sees empty, stays IDLE, and leaves next cycle.
- Total bytes storable before the first drop: 2^ASIZE + 1 (FIFO plus the output register).
- out_data holds its last value after the handshake; out_data is undefined-free (never X after reset).

Optional Feature:
- Macro: USB_SERIAL_RX_LEVEL_EN.
- Defined: level = wptr - rptr (ASIZE+1 bits, range 0..2^ASIZE), registered, updated every cycle and one cycle behind the pointers.
- Undefined: level is tied to 0 and no subtractor or register is built. All other behaviour is identical.

Test Plan:
- Reset release, 3 pulses of in_valid with bytes 0x41,0x42,0x43, out_ready=1 -> out_data sequence 0x41,0x42,0x43. First out_valid appears 2 cycles after the first write. overflow=0.
- out_ready=0, ASIZE=2, 6 bytes 0x10..0x15 pushed -> 0x10 is held in output, 0x11..0x14 fill the FIFO, 0x15 is dropped: overflow=1, drop_cnt=1. Then out_ready=1 -> 0x10..0x14 are delivered; 0x15 is never delivered.
- Overflow held (drop_cnt=3), ovf_clr pulse in the same cycle as a 4th drop -> overflow=1, drop_cnt=1. A later lone ovf_clr -> overflow=0, drop_cnt=0.
- Pointer wrap with ASIZE=2: stream 20 bytes, 40 clk apart, out_ready=1 -> all 20 are received in order and no drops occur.
- usb_rstn asserted while in HOLD with 3 bytes queued -> out_valid=0 immediately. After release no stale bytes appear and level=0 (with USB_SERIAL_RX_LEVEL_EN).
- With USB_SERIAL_RX_LEVEL_EN, out_ready=0, 5 bytes pushed at ASIZE=10 -> level settles at 4 (one byte sits in the output stage).
